// File: rtl/uart_rx_if.sv
// uart_rx bus: x16 tick, line and config in; received word and status out.
// slave is the receiver side, master is whoever drives the line and consumes words.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 baud_tick_x16_i;
    logic                 rx_en_i;
    logic                 parity_en_i;
    logic                 parity_odd_i;
    logic                 rx_i;
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_parity_err_o;
    logic                 rx_framing_err_o;
    logic                 rx_busy_o;

    modport slave (
        input  baud_tick_x16_i,
        input  rx_en_i,
        input  parity_en_i,
        input  parity_odd_i,
        input  rx_i,
        output rx_data_o,
        output rx_valid_o,
        output rx_parity_err_o,
        output rx_framing_err_o,
        output rx_busy_o
    );

    modport master (
        output baud_tick_x16_i,
        output rx_en_i,
        output parity_en_i,
        output parity_odd_i,
        output rx_i,
        input  rx_data_o,
        input  rx_valid_o,
        input  rx_parity_err_o,
        input  rx_framing_err_o,
        input  rx_busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver on the shared x16 baud tick, LSB-first, optional parity.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting at tick_cnt 6/7/8.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic      clk_i,
    input logic      rst_i,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [3:0]             tick_cnt_q, tick_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;

    logic rx_s;
    logic fall;
    logic samp;
    logic bit_v;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], bus.rx_i};
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign rx_prev_d = rx_s;
    assign fall      = rx_prev_q & ~rx_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic v6_q, v6_d;
    logic v7_q, v7_d;

    always_comb begin
        v6_d = v6_q;
        v7_d = v7_q;
        if (bus.baud_tick_x16_i && tick_cnt_q == 4'd6) v6_d = rx_s;
        if (bus.baud_tick_x16_i && tick_cnt_q == 4'd7) v7_d = rx_s;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v6_q <= 1'b1;
            v7_q <= 1'b1;
        end else begin
            v6_q <= v6_d;
            v7_q <= v7_d;
        end
    end

    assign samp  = bus.baud_tick_x16_i && tick_cnt_q == 4'd8;
    assign bit_v = (v6_q & v7_q) | (v6_q & rx_s) | (v7_q & rx_s);
`else
    assign samp  = bus.baud_tick_x16_i && tick_cnt_q == 4'd7;
    assign bit_v = rx_s;
`endif

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        par_bit_d  = par_bit_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        if (state_q != IDLE && bus.baud_tick_x16_i) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (fall && bus.rx_en_i) state_d = START;
            end
            START: begin
                if (samp) begin
                    if (bit_v) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                        par_en_d  = bus.parity_en_i;
                        par_odd_d = bus.parity_odd_i;
                    end
                end
            end
            DATA: begin
                if (samp) begin
                    shift_d   = {bit_v, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (samp) begin
                    par_bit_d = bit_v;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (samp) begin
                    state_d = IDLE;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = ~bit_v;
                    perr_d  = par_en_q & (^shift_q ^ par_bit_q ^ par_odd_q);
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable wins over everything, including a stop-bit load.
        if (state_q != IDLE && !bus.rx_en_i) begin
            state_d = IDLE;
            data_d  = data_q;
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
        end
        if (state_d == IDLE) tick_cnt_d = 4'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            rx_prev_q  <= rx_prev_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            par_bit_q  <= par_bit_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.rx_data_o        = data_q;
    assign bus.rx_valid_o       = valid_q;
    assign bus.rx_parity_err_o  = perr_q;
    assign bus.rx_framing_err_o = ferr_q;
    assign bus.rx_busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit by bit on the line and
// each received word is compared with a frame-level model of data and errors.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   bauds_lim = 0;
    int   checks = 0;
    int   passed = 0;
    int   flag_leak = 0;
    logic [9:0] got_q[$];

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        int div;
        div = 0;
        bus.baud_tick_x16_i = 1'b0;
        forever begin
            @(negedge clk);
            if (div >= bauds_lim) begin
                div = 0;
                bus.baud_tick_x16_i = 1'b1;
            end else begin
                div++;
                bus.baud_tick_x16_i = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (bus.rx_valid_o === 1'b1) begin
            got_q.push_back({bus.rx_framing_err_o, bus.rx_parity_err_o,
                             bus.rx_data_o});
        end else if (bus.rx_parity_err_o !== 1'b0 ||
                     bus.rx_framing_err_o !== 1'b0) begin
            flag_leak++;
        end
    end

    // Expected {framing_err, parity_err, data} for one frame on the wire.
    function automatic logic [9:0] model(input logic [7:0] d, input bit pen,
                                         input bit odd, input bit pb,
                                         input bit stop);
        int ones;
        bit want_pb;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        want_pb = ((ones % 2) == 1) ? !odd : odd;
        return {!stop, pen && (pb != want_pb), d};
    endfunction

    function automatic logic [9:0] pop_entry();
        if (got_q.size() == 0) return 10'bx;
        return got_q.pop_front();
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (bus.baud_tick_x16_i !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx_i = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pb,
                              input bit stop, input bit glitch, input bit flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = d[i];
            if (glitch) begin
                wait_ticks(7);
                bus.rx_i = ~d[i];
                wait_ticks(1);
                bus.rx_i = d[i];
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
            if (flip && i == 2) begin
                bus.parity_en_i  = ~bus.parity_en_i;
                bus.parity_odd_i = ~bus.parity_odd_i;
            end
        end
        if (pen) send_bit(pb);
        send_bit(stop);
    endtask

    task automatic test_reset;
        bus.rx_i = 1'b1;
        bus.rx_en_i = 1'b1;
        bus.parity_en_i = 1'b0;
        bus.parity_odd_i = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rx_data_o !== 8'h00) $display("FAIL rst_data got=%h exp=00", bus.rx_data_o);
        else passed++;
        checks++;
        if (bus.rx_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", bus.rx_valid_o);
        else passed++;
        checks++;
        if (bus.rx_busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.rx_busy_o);
        else passed++;
        checks++;
        if ({bus.rx_parity_err_o, bus.rx_framing_err_o} !== 2'b00)
            $display("FAIL rst_flags got=%b%b exp=00", bus.rx_parity_err_o, bus.rx_framing_err_o);
        else passed++;
        rst = 1'b0;
        wait_ticks(20);
        checks++;
        if (bus.rx_busy_o !== 1'b0 || got_q.size() != 0)
            $display("FAIL post_rst_idle got busy=%b n=%0d exp busy=0 n=0", bus.rx_busy_o, got_q.size());
        else passed++;
    endtask

    task automatic test_8n1;
        logic [9:0] e, x;
        bauds_lim = 0;
        send_frame(8'hA5, 0, 0, 1, 0, 0);
        wait_ticks(4);
        x = model(8'hA5, 0, 0, 0, 1);
        checks++;
        if (got_q.size() != 1) $display("FAIL a5_count got=%0d exp=1", got_q.size());
        else passed++;
        e = pop_entry();
        checks++;
        if (e !== x) $display("FAIL a5_word got=%h exp=%h", e, x);
        else passed++;
        checks++;
        if (bus.rx_busy_o !== 1'b0) $display("FAIL a5_busy got=%b exp=0", bus.rx_busy_o);
        else passed++;
    endtask

    task automatic test_parity;
        logic [9:0] e, x;
        bit pbs[3] = '{1'b0, 1'b1, 1'b1};
        bit odds[3] = '{1'b0, 1'b0, 1'b1};
        bus.parity_en_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.parity_odd_i = odds[k];
            send_frame(8'h03, 1, pbs[k], 1, 0, 0);
            wait_ticks(20);
            x = model(8'h03, 1, odds[k], pbs[k], 1);
            e = pop_entry();
            checks++;
            if (e !== x || got_q.size() != 0)
                $display("FAIL parity_%0d got=%h exp=%h", k, e, x);
            else passed++;
        end
        bus.parity_en_i = 1'b0;
        bus.parity_odd_i = 1'b0;
    endtask

    task automatic test_framing_break;
        logic [9:0] e, x;
        send_frame(8'h55, 0, 0, 0, 0, 0);
        wait_ticks(4);
        x = model(8'h55, 0, 0, 0, 0);
        e = pop_entry();
        checks++;
        if (e !== x) $display("FAIL framing_word got=%h exp=%h", e, x);
        else passed++;
        wait_ticks(40 * 16);
        checks++;
        if (got_q.size() != 0) $display("FAIL break_retrigger got=%0d exp=0", got_q.size());
        else passed++;
        bus.rx_i = 1'b1;
        wait_ticks(32);
        send_frame(8'h0F, 0, 0, 1, 0, 0);
        wait_ticks(20);
        x = model(8'h0F, 0, 0, 0, 1);
        e = pop_entry();
        checks++;
        if (e !== x) $display("FAIL after_break got=%h exp=%h", e, x);
        else passed++;
    endtask

    task automatic test_false_start;
        logic [9:0] e, x;
        bus.rx_i = 1'b0;
        wait_ticks(4);
        bus.rx_i = 1'b1;
        wait_ticks(40);
        checks++;
        if (got_q.size() != 0 || bus.rx_busy_o !== 1'b0)
            $display("FAIL false_start got n=%0d busy=%b exp n=0 busy=0", got_q.size(), bus.rx_busy_o);
        else passed++;
        send_frame(8'h81, 0, 0, 1, 0, 0);
        wait_ticks(20);
        x = model(8'h81, 0, 0, 0, 1);
        e = pop_entry();
        checks++;
        if (e !== x) $display("FAIL after_glitch got=%h exp=%h", e, x);
        else passed++;
    endtask

    task automatic test_enable_abort;
        logic [9:0] e, x;
        send_bit(1'b0);
        repeat (3) send_bit(1'b1);
        bus.rx_i = 1'b1;
        wait_ticks(4);
        checks++;
        if (bus.rx_busy_o !== 1'b1) $display("FAIL busy_mid_frame got=%b exp=1", bus.rx_busy_o);
        else passed++;
        bus.rx_en_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rx_busy_o !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.rx_busy_o);
        else passed++;
        wait_ticks(200);
        checks++;
        if (got_q.size() != 0) $display("FAIL abort_valid got=%0d exp=0", got_q.size());
        else passed++;
        bus.rx_en_i = 1'b1;
        wait_ticks(16);
        send_frame(8'h3C, 0, 0, 1, 0, 0);
        wait_ticks(20);
        x = model(8'h3C, 0, 0, 0, 1);
        e = pop_entry();
        checks++;
        if (e !== x) $display("FAIL after_abort got=%h exp=%h", e, x);
        else passed++;
    endtask

    task automatic test_config_hold;
        logic [9:0] e, x;
        bauds_lim = 1;
        bus.parity_en_i = 1'b1;
        bus.parity_odd_i = 1'b0;
        wait_ticks(16);
        send_frame(8'h07, 1, 0, 1, 0, 1);
        wait_ticks(20);
        x = model(8'h07, 1, 0, 0, 1);
        e = pop_entry();
        checks++;
        if (e !== x || got_q.size() != 0)
            $display("FAIL config_hold got=%h exp=%h", e, x);
        else passed++;
        bus.parity_en_i = 1'b0;
        bus.parity_odd_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h5A};
        logic [9:0] e, x;
        bit glitch;
`ifdef UART_RX_MAJORITY_VOTE_EN
        glitch = 1'b1;
`else
        glitch = 1'b0;
`endif
        bauds_lim = 3;
        wait_ticks(16);
        for (int k = 0; k < 3; k++) send_frame(bytes[k], 0, 0, 1, glitch, 0);
        bus.rx_i = 1'b1;
        wait_ticks(16);
        checks++;
        if (got_q.size() != 3) $display("FAIL b2b_count got=%0d exp=3", got_q.size());
        else passed++;
        for (int k = 0; k < 3; k++) begin
            x = model(bytes[k], 0, 0, 0, 1);
            e = pop_entry();
            checks++;
            if (e !== x) $display("FAIL b2b_%0d got=%h exp=%h", k, e, x);
            else passed++;
        end
    endtask

    task automatic test_random;
        logic [9:0] e, x;
        logic [7:0] d;
        bit pen, odd, pb, stop;
        for (int k = 0; k < 12; k++) begin
            bauds_lim = $urandom_range(0, 3);
            d = 8'($urandom);
            pen = 1'($urandom);
            odd = 1'($urandom);
            pb = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            bus.parity_en_i = pen;
            bus.parity_odd_i = odd;
            wait_ticks(4);
            send_frame(d, pen, pb, stop, 0, 0);
            bus.rx_i = 1'b1;
            wait_ticks(24);
            x = model(d, pen, odd, pb, stop);
            checks++;
            if (got_q.size() != 1) $display("FAIL rand_%0d_count got=%0d exp=1", k, got_q.size());
            else passed++;
            e = pop_entry();
            checks++;
            if (e !== x) $display("FAIL rand_%0d_word got=%h exp=%h", k, e, x);
            else passed++;
            got_q.delete();
        end
        checks++;
        if (flag_leak != 0) $display("FAIL flags_unqualified got=%0d exp=0", flag_leak);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing_break();
        test_false_start();
        test_enable_abort();
        test_config_hold();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
